// File: rtl/j1_uart_io.sv
// +--------------------------------------------------------------------------+
// | j1_uart_io : memory-mapped 8N1 UART (TX data, RX holding reg, status)    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module j1_uart_io #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter logic [15:0] DATA_ADDR    = 16'h1000,
  parameter logic [15:0] STAT_ADDR    = 16'h2000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic w_data_rd;
  logic w_stat_rd;
  logic w_data_wr;
  logic w_unused;

  assign w_data_rd = io_rd && (io_addr == DATA_ADDR);
  assign w_stat_rd = io_rd && (io_addr == STAT_ADDR);
  assign w_data_wr = io_wr && (io_addr == DATA_ADDR);
  assign w_unused  = ^io_wdata[15:8];

  // ---------------------------------------------------------------- TX path
  logic [1:0]    r_tx_state;
  logic [1:0]    w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [2:0]    w_tx_idx_next;
  logic [7:0]    r_tx_byte;
  logic          r_uart_tx;
  logic          w_tx_line;
  logic          w_tx_tick;
  logic          w_tx_ready;

  assign w_tx_tick  = (r_tx_cnt == c_BIT_LAST);
  assign w_tx_ready = (r_tx_state == c_IDLE);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_state <= c_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next     = r_tx_state;
    w_tx_idx_next = r_tx_idx;
    case (r_tx_state)
      c_IDLE: begin
        w_tx_idx_next = 3'd0;
        if (w_data_wr) w_tx_next = c_START;
      end
      c_START: begin
        w_tx_idx_next = 3'd0;
        if (w_tx_tick) w_tx_next = c_DATA;
      end
      c_DATA: begin
        if (w_tx_tick) begin
          if (r_tx_idx == 3'd7) w_tx_next = c_STOP;
          else                  w_tx_idx_next = r_tx_idx + 3'd1;
        end
      end
      c_STOP: begin
        if (w_tx_tick) w_tx_next = c_IDLE;
      end
      default: w_tx_next = c_IDLE;
    endcase
  end

  // Line level is decoded from the next state so uart_tx itself is a flop.
  always_comb begin
    w_tx_line = 1'b1;
    case (w_tx_next)
      c_START: w_tx_line = 1'b0;
      c_DATA:  w_tx_line = r_tx_byte[w_tx_idx_next];
      default: w_tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_cnt  <= '0;
      r_tx_idx  <= 3'd0;
      r_tx_byte <= 8'h00;
      r_uart_tx <= 1'b1;
    end else begin
      r_tx_cnt  <= (r_tx_state == c_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
      r_tx_idx  <= w_tx_idx_next;
      r_uart_tx <= w_tx_line;
      if (r_tx_state == c_IDLE && w_data_wr) r_tx_byte <= io_wdata[7:0];
    end
  end

  assign uart_tx = r_uart_tx;

  // ---------------------------------------------------------------- RX path
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  logic          w_rx_fall;
  logic [1:0]    r_rx_state;
  logic [1:0]    w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          w_rx_tick;
  logic          w_rx_shift_en;
  logic          w_rx_done_ok;
  logic          w_rx_done_err;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_rx_tick = (r_rx_state == c_START) ? (r_rx_cnt == c_HALF_LAST)
                                             : (r_rx_cnt == c_BIT_LAST);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_state <= c_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      c_IDLE:  if (w_rx_fall) w_rx_next = c_START;
      c_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? c_IDLE : c_DATA;
      c_DATA:  if (w_rx_tick && r_rx_idx == 3'd7) w_rx_next = c_STOP;
      c_STOP:  if (w_rx_tick) w_rx_next = c_IDLE;
      default: w_rx_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_rx_shift_en = 1'b0;
    w_rx_done_ok  = 1'b0;
    w_rx_done_err = 1'b0;
    case (r_rx_state)
      c_DATA: w_rx_shift_en = w_rx_tick;
      c_STOP: begin
        w_rx_done_ok  = w_rx_tick && r_rx_s2;
        w_rx_done_err = w_rx_tick && !r_rx_s2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_cnt <= (r_rx_state == c_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 1'b1;
      if (r_rx_state != c_DATA) r_rx_idx <= 3'd0;
      else if (w_rx_tick)       r_rx_idx <= r_rx_idx + 3'd1;
      if (w_rx_shift_en) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
    end
  end

  // ------------------------------------------------------ flags and readback
  logic        r_rx_valid;
  logic        r_overrun;
  logic        r_frame_err;
  logic [7:0]  r_rx_data;
  logic [15:0] r_io_rdata;
  logic [15:0] w_status;

  assign w_status = {12'h000, r_frame_err, r_overrun, r_rx_valid, w_tx_ready};

  // Set beats clear on every flag; a data read racing completion is not an overrun.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_data   <= 8'h00;
      r_io_rdata  <= 16'h0000;
    end else begin
      if (w_rx_done_ok)   r_rx_valid <= 1'b1;
      else if (w_data_rd) r_rx_valid <= 1'b0;

      if (w_rx_done_ok && r_rx_valid && !w_data_rd) r_overrun <= 1'b1;
      else if (w_stat_rd)                           r_overrun <= 1'b0;

      if (w_rx_done_err)  r_frame_err <= 1'b1;
      else if (w_stat_rd) r_frame_err <= 1'b0;

      if (w_rx_done_ok) r_rx_data <= r_rx_shift;

      if (io_rd) begin
        if (w_data_rd)      r_io_rdata <= {8'h00, r_rx_data};
        else if (w_stat_rd) r_io_rdata <= w_status;
        else                r_io_rdata <= 16'h0000;
      end
    end
  end

  assign io_rdata = r_io_rdata;

endmodule

`default_nettype wire

// File: tb/tb_j1_uart_io.sv
// +--------------------------------------------------------------------------+
// | tb_j1_uart_io : directed self-checking bench for j1_uart_io (8 clk/bit)  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_j1_uart_io;

  localparam int unsigned CPB  = 8;
  localparam logic [15:0] DATA = 16'h1000;
  localparam logic [15:0] STAT = 16'h2000;

  logic        clk;
  logic        resetq;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        uart_rx;
  logic        uart_tx;

  int n_tests;
  int n_fail;

  j1_uart_io #(
    .CLKS_PER_BIT(CPB),
    .DATA_ADDR   (DATA),
    .STAT_ADDR   (STAT)
  ) dut (
    .clk     (clk),
    .resetq  (resetq),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    io_rd   = 1'b1;
    io_addr = a;
    @(negedge clk);
    io_rd   = 1'b0;
    d       = io_rdata;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends one byte while polling status every cycle; optionally injects a write at cycle 20.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] exp_frame, input bit drop_wr);
    logic [79:0] smp;
    int          zeros;
    smp   = '0;
    zeros = 0;
    @(negedge clk);
    io_wr    = 1'b1;
    io_rd    = 1'b0;
    io_addr  = DATA;
    io_wdata = {8'h00, b};
    for (int k = 0; k < 82; k++) begin
      @(negedge clk);
      if (k < 80) smp[k] = uart_tx;
      if (k >= 1 && k <= 80 && io_rdata[0] == 1'b0) zeros++;
      if (k == 81) check("tx_ready_after_frame", {15'h0000, io_rdata[0]}, 16'h0001);
      if (drop_wr && k == 19) begin
        io_wr    = 1'b1;
        io_rd    = 1'b0;
        io_addr  = DATA;
        io_wdata = 16'h00FF;
      end else begin
        io_wr   = 1'b0;
        io_rd   = 1'b1;
        io_addr = STAT;
      end
    end
    io_rd = 1'b0;
    io_wr = 1'b0;
    for (int i = 0; i < 10; i++)
      check($sformatf("tx_bit%0d", i), {8'h00, smp[i*8 +: 8]}, {8'h00, {8{exp_frame[i]}}});
    check("tx_busy_cycles", 16'(zeros), 16'd80);
  endtask

  initial begin
    logic [15:0] d;
    n_tests  = 0;
    n_fail   = 0;
    resetq   = 1'b0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    io_addr  = 16'h0000;
    io_wdata = 16'h0000;
    uart_rx  = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_uart_tx", {15'h0000, uart_tx}, 16'h0001);
    check("reset_rdata", io_rdata, 16'h0000);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    io_read(STAT, d);
    check("stat_after_reset", d, 16'h0001);

    // A5 -> 0,1,0,1,0,0,1,0,1,1 on the wire; the cycle-20 write must be ignored
    tx_frame(8'hA5, 10'b1101001010, 1'b1);
    check("tx_idle_line", {15'h0000, uart_tx}, 16'h0001);

    rx_byte(8'h3C, 1'b1);
    io_read(STAT, d);
    check("stat_rx_valid", d, 16'h0003);
    io_read(16'h3000, d);
    check("unmapped_read", d, 16'h0000);
    io_read(DATA, d);
    check("rx_data_3c", d, 16'h003C);
    io_read(STAT, d);
    check("stat_after_data_read", d, 16'h0001);

    rx_byte(8'h11, 1'b1);
    repeat (2) @(negedge clk);
    rx_byte(8'h22, 1'b1);
    io_read(DATA, d);
    check("rx_overrun_data", d, 16'h0022);
    io_read(STAT, d);
    check("stat_overrun", d, 16'h0005);
    io_read(STAT, d);
    check("stat_overrun_cleared", d, 16'h0001);

    rx_byte(8'h55, 1'b0);
    io_read(STAT, d);
    check("stat_frame_err", d, 16'h0009);
    io_read(DATA, d);
    check("rx_data_kept", d, 16'h0022);
    io_read(STAT, d);
    check("stat_frame_err_cleared", d, 16'h0001);

    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (16) @(negedge clk);
    io_read(STAT, d);
    check("stat_after_glitch", d, 16'h0001);

    // reset while an all-zero frame is on the wire
    @(negedge clk);
    io_wr    = 1'b1;
    io_addr  = DATA;
    io_wdata = 16'h0000;
    @(negedge clk);
    io_wr = 1'b0;
    repeat (30) @(negedge clk);
    check("tx_low_before_reset", {15'h0000, uart_tx}, 16'h0000);
    #2;
    resetq = 1'b0;
    #1;
    check("tx_high_in_reset", {15'h0000, uart_tx}, 16'h0001);
    check("rdata_in_reset", io_rdata, 16'h0000);
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(negedge clk);
    io_read(STAT, d);
    check("stat_after_mid_reset", d, 16'h0001);

    tx_frame(8'h5A, 10'b1010110100, 1'b0);
    check("tx_idle_line_final", {15'h0000, uart_tx}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
